// File: rtl/sum_tree_pkg.sv
// Width/depth helpers shared by the reduction tree and its levels.
// Pure constant functions; no logic, no latency, no flow control.
package sum_tree_pkg;

  function automatic int level_count(input int num_in);
    return (num_in > 1) ? $clog2(num_in) : 0;
  endfunction

  function automatic int full_width(input int num_in, input int data_w);
    return data_w + level_count(num_in);
  endfunction

  function automatic int latency(input int num_in, input int pipe);
    return (pipe != 0 && level_count(num_in) > 1) ? level_count(num_in) : 1;
  endfunction

  // Terms entering level lvl: ceil(num_in / 2**lvl).
  function automatic int level_terms(input int num_in, input int lvl);
    return (num_in + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic int pair_count(input int m);
    return (m + 1) / 2;
  endfunction

endpackage

// File: rtl/sum_tree_level.sv
// One adder-tree level: M terms of W bits -> ceil(M/2) sums of W+1 bits, odd term zero-extended.
// Latency 0 (PIPE=0) or 1 (PIPE=1); no backpressure, a new set of terms is taken every clock.
module sum_tree_level
  import sum_tree_pkg::*;
#(
  parameter int M    = 2,
  parameter int W    = 3,
  parameter int PIPE = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [M*W-1:0]                     term_dat,
  output logic [pair_count(M)*(W+1)-1:0]     sum_dat
);

  localparam int N  = pair_count(M);
  localparam int OW = W + 1;

  logic [N*OW-1:0] pair_sum;

  for (genvar j = 0; j < N; j++) begin : g_pair
    if (2*j + 1 < M) begin : g_add
      assign pair_sum[j*OW +: OW] = OW'(term_dat[2*j*W +: W]) + OW'(term_dat[(2*j+1)*W +: W]);
    end else begin : g_pass
      assign pair_sum[j*OW +: OW] = OW'(term_dat[2*j*W +: W]);
    end
  end

  if (PIPE != 0) begin : g_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_dat <= '0;
      else      sum_dat <= pair_sum;
    end
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign sum_dat = pair_sum;
  end

endmodule

// File: rtl/sum_tree.sv
// Unsigned reduction adder of NUM_IN packed elements with truncated sum, full sum and overflow.
// Latency 1 (PIPE=0) or max(1,clog2(NUM_IN)) (PIPE=1); no backpressure, one result per clock.
module sum_tree
  import sum_tree_pkg::*;
#(
  parameter int  NUM_IN = 4,
  parameter int  DATA_W = 3,
  parameter int  SUM_W  = 3,
  parameter int  PIPE   = 0,
  localparam int FULL_W = full_width(NUM_IN, DATA_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] inputs,
  output logic [SUM_W-1:0]         sum,
  output logic [FULL_W-1:0]        sum_full,
  output logic                     overflow,
  output logic                     out_valid
);

  localparam int NL    = level_count(NUM_IN);
  localparam int LAT   = latency(NUM_IN, PIPE);
  localparam int CNT_W = $clog2(LAT + 1);

  logic [FULL_W-1:0] tree_sum;

  for (genvar k = 0; k < NL; k++) begin : lvl
    localparam int M = level_terms(NUM_IN, k);
    localparam int W = DATA_W + k;

    logic [M*W-1:0]                  term_dat;
    logic [pair_count(M)*(W+1)-1:0]  sum_dat;

    if (k == 0) begin : g_first
      assign term_dat = inputs;
    end else begin : g_next
      assign term_dat = lvl[k-1].sum_dat;
    end

    sum_tree_level #(.M(M), .W(W), .PIPE(PIPE)) u_level (
      .clk      (clk),
      .rst      (rst),
      .term_dat (term_dat),
      .sum_dat  (sum_dat)
    );
  end

  if (NL == 0) begin : g_single
    assign tree_sum = inputs;
  end else begin : g_tree
    assign tree_sum = lvl[NL-1].sum_dat;
  end

  // A pipelined tree already ends in a register; only add one when nothing else registers.
  if (PIPE == 0 || NL == 0) begin : g_out_reg
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sum_full <= '0;
      else      sum_full <= tree_sum;
    end
  end else begin : g_out_pipe
    assign sum_full = tree_sum;
  end

  if (SUM_W <= FULL_W) begin : g_trunc
    assign sum = sum_full[SUM_W-1:0];
  end else begin : g_zext
    assign sum = {{(SUM_W-FULL_W){1'b0}}, sum_full};
  end

  if (SUM_W < FULL_W) begin : g_ovf
    assign overflow = |sum_full[FULL_W-1:SUM_W];
  end else begin : g_no_ovf
    assign overflow = 1'b0;
  end

  logic [CNT_W-1:0] fill_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           fill_cnt <= '0;
    else if (fill_cnt != CNT_W'(LAT))   fill_cnt <= fill_cnt + CNT_W'(1);
  end

  assign out_valid = (fill_cnt == CNT_W'(LAT));

endmodule

// File: tb/tb_sum_tree.sv
// Bench for sum_tree: five parameterisations share one clock/reset and are compared against
// an arithmetic model (element sum, delayed by the expected latency).
module tb_sum_tree;

  localparam int ND = 5;
  localparam int NI [ND] = '{4, 4, 5, 1, 5};
  localparam int DW [ND] = '{3, 3, 4, 3, 4};
  localparam int SW [ND] = '{3, 3, 7, 3, 5};
  localparam int LT [ND] = '{1, 2, 1, 1, 3};

  logic        clk;
  logic        rst;
  logic [19:0] bus [ND];

  logic [2:0] sum0;  logic [4:0] full0;
  logic [2:0] sum1;  logic [4:0] full1;
  logic [6:0] sum2;  logic [6:0] full2;
  logic [2:0] sum3;  logic [2:0] full3;
  logic [4:0] sum4;  logic [6:0] full4;
  logic       ov  [ND];
  logic       vld [ND];
  logic [6:0] o_sum  [ND];
  logic [6:0] o_full [ND];

  assign o_sum[0] = {4'b0, sum0};  assign o_full[0] = {2'b0, full0};
  assign o_sum[1] = {4'b0, sum1};  assign o_full[1] = {2'b0, full1};
  assign o_sum[2] = sum2;          assign o_full[2] = full2;
  assign o_sum[3] = {4'b0, sum3};  assign o_full[3] = {4'b0, full3};
  assign o_sum[4] = {2'b0, sum4};  assign o_full[4] = full4;

  sum_tree #(.NUM_IN(4), .DATA_W(3), .SUM_W(3), .PIPE(0)) d0 (
    .clk(clk), .rst(rst), .inputs(bus[0][11:0]), .sum(sum0), .sum_full(full0),
    .overflow(ov[0]), .out_valid(vld[0]));
  sum_tree #(.NUM_IN(4), .DATA_W(3), .SUM_W(3), .PIPE(1)) d1 (
    .clk(clk), .rst(rst), .inputs(bus[1][11:0]), .sum(sum1), .sum_full(full1),
    .overflow(ov[1]), .out_valid(vld[1]));
  sum_tree #(.NUM_IN(5), .DATA_W(4), .SUM_W(7), .PIPE(0)) d2 (
    .clk(clk), .rst(rst), .inputs(bus[2][19:0]), .sum(sum2), .sum_full(full2),
    .overflow(ov[2]), .out_valid(vld[2]));
  sum_tree #(.NUM_IN(1), .DATA_W(3), .SUM_W(3), .PIPE(0)) d3 (
    .clk(clk), .rst(rst), .inputs(bus[3][2:0]), .sum(sum3), .sum_full(full3),
    .overflow(ov[3]), .out_valid(vld[3]));
  sum_tree #(.NUM_IN(5), .DATA_W(4), .SUM_W(5), .PIPE(1)) d4 (
    .clk(clk), .rst(rst), .inputs(bus[4][19:0]), .sum(sum4), .sum_full(full4),
    .overflow(ov[4]), .out_valid(vld[4]));

  int total;
  int bad;
  int n;
  int hist [ND][256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_sum(input logic [19:0] b, input int cnt, input int w);
    int s = 0;
    for (int i = 0; i < cnt; i++) s += int'((b >> (i*w)) & ((20'd1 << w) - 20'd1));
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    for (int d = 0; d < ND; d++) begin
      int full_e = (n >= LT[d]) ? hist[d][n - LT[d]] : 0;
      chk($sformatf("%s d%0d sum", where, d),  32'(o_sum[d]),  32'(full_e % (1 << SW[d])));
      chk($sformatf("%s d%0d full", where, d), 32'(o_full[d]), 32'(full_e));
      chk($sformatf("%s d%0d ovf", where, d),  32'(ov[d]),     32'(full_e >= (1 << SW[d])));
      chk($sformatf("%s d%0d vld", where, d),  32'(vld[d]),    32'(n >= LT[d]));
    end
  endtask

  task automatic randomize_bus();
    for (int d = 0; d < ND; d++)
      bus[d] = 20'($urandom_range(0, (1 << (NI[d]*DW[d])) - 1));
  endtask

  // Records what the DUTs sample at the next edge; optional glitch between edges must be ignored.
  task automatic step(input bit glitch);
    for (int d = 0; d < ND; d++) hist[d][n] = ref_sum(bus[d], NI[d], DW[d]);
    @(posedge clk);
    n++;
    if (glitch) begin
      #2;
      randomize_bus();
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    n     = 0;
    rst   = 1'b0;
    for (int d = 0; d < ND; d++) bus[d] = '0;
    @(negedge clk);
    @(negedge clk);
    check_all("reset");

    rst = 1'b1;
    bus[0] = 20'h482; bus[1] = 20'h001; bus[2] = 20'hFFFFF; bus[3] = 20'h5; bus[4] = 20'hFFFFF;
    step(1'b0);
    check_all("t1");

    bus[0] = 20'hFFF; bus[1] = 20'h249; bus[2] = 20'h0; bus[3] = 20'h7; bus[4] = 20'h12345;
    step(1'b0);
    check_all("t2");

    bus[0] = 20'h0; bus[1] = 20'hFFF; bus[2] = 20'h8421; bus[3] = 20'h0; bus[4] = 20'h0;
    step(1'b0);
    check_all("t3");

    bus[1] = 20'h0;
    step(1'b0);
    check_all("t4");

    for (int i = 0; i < 60; i++) begin
      randomize_bus();
      step(1'b1);
      check_all("rnd");
    end

    randomize_bus();
    bus[0] = 20'hFFF;
    rst = 1'b0;
    #1;
    n = 0;
    check_all("rst_async");
    @(negedge clk);
    check_all("rst_hold");

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0);
      check_all("refill");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
